// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end: oversampled start-edge detection, mid-bit sampling,
// one-cycle RX_END / RX_ERR strobes and a busy flag spanning each frame.
module uart_rx_frontend #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_END,
  output logic       RX_ERR,
  output logic       RX_BUSY
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] s_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          tick;
  logic          sample_mid;
  logic          sample_full;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  assign tick        = (tick_cnt == TICK_LAST);
  assign sample_mid  = tick && (s_cnt == S_MID);
  assign sample_full = tick && (s_cnt == S_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      s_cnt    <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      RX_DATA  <= 8'h00;
      RX_END   <= 1'b0;
      RX_ERR   <= 1'b0;
      RX_BUSY  <= 1'b0;
    end else begin
      RX_END <= 1'b0;
      RX_ERR <= 1'b0;

      if (tick) tick_cnt <= '0;
      else      tick_cnt <= tick_cnt + TW'(1);

      if (tick) s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + SW'(1);

      case (state)
        IDLE: begin
          if (!rx_s) begin
            // Restart both counters so every later sample lands relative to this edge.
            state    <= START;
            tick_cnt <= '0;
            s_cnt    <= '0;
            RX_BUSY  <= 1'b1;
          end
        end
        START: begin
          if (sample_mid) begin
            if (rx_s) begin
              state   <= IDLE;
              RX_BUSY <= 1'b0;
            end else begin
              s_cnt   <= '0;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (sample_full) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (sample_full) begin
            if (rx_s) begin
              RX_DATA <= shreg;
              RX_END  <= 1'b1;
              RX_BUSY <= 1'b0;
              state   <= IDLE;
            end else begin
              RX_ERR <= 1'b1;
              state  <= BREAK;
            end
          end
        end
        BREAK: begin
          // A held-low line must not retrigger; wait for it to return to idle.
          if (rx_s) begin
            state   <= IDLE;
            RX_BUSY <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          RX_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend, scaled so one sample tick is 4 clocks (64 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_frontend;

  localparam real BIT_NS = 640.0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       UART_RX = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_END;
  logic       RX_ERR;
  logic       RX_BUSY;

  int checks = 0;
  int failures = 0;

  int end_cnt = 0;
  int err_cnt = 0;
  int width_bad = 0;
  int overlap_bad = 0;
  logic prev_end = 1'b0;
  logic prev_err = 1'b0;
  logic [7:0] data_log[$];

  uart_rx_frontend #(
    .CLK_FREQ  (614_400),
    .BAUD      (9600),
    .OVERSAMPLE(16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .UART_RX(UART_RX),
    .RX_DATA(RX_DATA),
    .RX_END (RX_END),
    .RX_ERR (RX_ERR),
    .RX_BUSY(RX_BUSY)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (RX_END) begin
      end_cnt = end_cnt + 1;
      data_log.push_back(RX_DATA);
    end
    if (RX_ERR) err_cnt = err_cnt + 1;
    if ((RX_END && prev_end) || (RX_ERR && prev_err)) width_bad = width_bad + 1;
    if (RX_END && RX_ERR) overlap_bad = overlap_bad + 1;
    prev_end = RX_END;
    prev_err = RX_ERR;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    UART_RX = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      #(bit_ns);
    end
    UART_RX = stop_bit;
    #(bit_ns);
    UART_RX = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (RX_DATA !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", RX_DATA); end
    checks++; if (RX_END !== 1'b0) begin failures++; $display("FAIL reset_end got=%b exp=0", RX_END); end
    checks++; if (RX_ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", RX_ERR); end
    checks++; if (RX_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", RX_BUSY); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int e0, r0, w0, o0;
    logic [7:0] got;
    e0 = end_cnt; r0 = err_cnt; w0 = width_bad; o0 = overlap_bad;
    send_frame(8'h55, 1'b1, BIT_NS);
    #(BIT_NS);
    got = (data_log.size() > e0) ? data_log[e0] : 8'hxx;
    $display("single: tx=55 rx=%h ends=%0d errs=%0d", got, end_cnt - e0, err_cnt - r0);
    checks++; if (end_cnt - e0 !== 1) begin failures++; $display("FAIL single_end_count got=%0d exp=1", end_cnt - e0); end
    checks++; if (got !== 8'h55) begin failures++; $display("FAIL single_data got=%h exp=55", got); end
    checks++; if (err_cnt - r0 !== 0) begin failures++; $display("FAIL single_err_count got=%0d exp=0", err_cnt - r0); end
    checks++; if (width_bad - w0 !== 0) begin failures++; $display("FAIL single_pulse_width got=%0d exp=0", width_bad - w0); end
    checks++; if (overlap_bad - o0 !== 0) begin failures++; $display("FAIL single_overlap got=%0d exp=0", overlap_bad - o0); end
  endtask

  task automatic test_back_to_back();
    int e0, r0;
    logic [7:0] g0, g1;
    e0 = end_cnt; r0 = err_cnt;
    send_frame(8'hA3, 1'b1, BIT_NS);
    send_frame(8'h0F, 1'b1, BIT_NS);
    #(BIT_NS);
    g0 = (data_log.size() > e0) ? data_log[e0] : 8'hxx;
    g1 = (data_log.size() > e0 + 1) ? data_log[e0 + 1] : 8'hxx;
    $display("back_to_back: tx=A3,0F rx=%h,%h ends=%0d", g0, g1, end_cnt - e0);
    checks++; if (end_cnt - e0 !== 2) begin failures++; $display("FAIL b2b_end_count got=%0d exp=2", end_cnt - e0); end
    checks++; if (g0 !== 8'hA3) begin failures++; $display("FAIL b2b_first got=%h exp=A3", g0); end
    checks++; if (g1 !== 8'h0F) begin failures++; $display("FAIL b2b_second got=%h exp=0F", g1); end
    checks++; if (err_cnt - r0 !== 0) begin failures++; $display("FAIL b2b_err_count got=%0d exp=0", err_cnt - r0); end
  endtask

  task automatic test_glitch();
    int e0, r0;
    e0 = end_cnt; r0 = err_cnt;
    UART_RX = 1'b0;
    #120;
    UART_RX = 1'b1;
    #100;
    $display("glitch: busy_during=%b", RX_BUSY);
    checks++; if (RX_BUSY !== 1'b1) begin failures++; $display("FAIL glitch_busy_set got=%b exp=1", RX_BUSY); end
    #(BIT_NS);
    checks++; if (RX_BUSY !== 1'b0) begin failures++; $display("FAIL glitch_busy_clear got=%b exp=0", RX_BUSY); end
    checks++; if (end_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_end_count got=%0d exp=0", end_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin failures++; $display("FAIL glitch_err_count got=%0d exp=0", err_cnt - r0); end
  endtask

  task automatic test_framing_error();
    int e0, r0;
    e0 = end_cnt; r0 = err_cnt;
    send_frame(8'h81, 1'b0, BIT_NS);
    #(BIT_NS);
    $display("framing: tx=81/stop0 errs=%0d ends=%0d data=%h", err_cnt - r0, end_cnt - e0, RX_DATA);
    checks++; if (err_cnt - r0 !== 1) begin failures++; $display("FAIL ferr_err_count got=%0d exp=1", err_cnt - r0); end
    checks++; if (end_cnt - e0 !== 0) begin failures++; $display("FAIL ferr_end_count got=%0d exp=0", end_cnt - e0); end
    checks++; if (RX_DATA !== 8'h0F) begin failures++; $display("FAIL ferr_data_held got=%h exp=0F", RX_DATA); end
    checks++; if (RX_BUSY !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%b exp=0", RX_BUSY); end
    send_frame(8'h3C, 1'b1, BIT_NS);
    #(BIT_NS);
    $display("framing: tx=3C rx=%h ends=%0d", RX_DATA, end_cnt - e0);
    checks++; if (end_cnt - e0 !== 1) begin failures++; $display("FAIL ferr_recover_end got=%0d exp=1", end_cnt - e0); end
    checks++; if (RX_DATA !== 8'h3C) begin failures++; $display("FAIL ferr_recover_data got=%h exp=3C", RX_DATA); end
    checks++; if (err_cnt - r0 !== 1) begin failures++; $display("FAIL ferr_recover_err got=%0d exp=1", err_cnt - r0); end
  endtask

  task automatic test_break();
    int e0, r0;
    e0 = end_cnt; r0 = err_cnt;
    UART_RX = 1'b0;
    #(15.0 * BIT_NS);
    checks++; if (RX_BUSY !== 1'b1) begin failures++; $display("FAIL break_busy_mid got=%b exp=1", RX_BUSY); end
    #(15.0 * BIT_NS);
    $display("break: errs=%0d ends=%0d busy=%b", err_cnt - r0, end_cnt - e0, RX_BUSY);
    checks++; if (err_cnt - r0 !== 1) begin failures++; $display("FAIL break_err_count got=%0d exp=1", err_cnt - r0); end
    checks++; if (end_cnt - e0 !== 0) begin failures++; $display("FAIL break_end_count got=%0d exp=0", end_cnt - e0); end
    checks++; if (RX_BUSY !== 1'b1) begin failures++; $display("FAIL break_busy_end got=%b exp=1", RX_BUSY); end
    UART_RX = 1'b1;
    #(BIT_NS);
    checks++; if (RX_BUSY !== 1'b0) begin failures++; $display("FAIL break_busy_release got=%b exp=0", RX_BUSY); end
    checks++; if (err_cnt - r0 !== 1) begin failures++; $display("FAIL break_err_final got=%0d exp=1", err_cnt - r0); end
  endtask

  task automatic test_reset_midframe();
    int e0;
    UART_RX = 1'b0;
    #(BIT_NS);
    UART_RX = 1'b1;
    #(4.5 * BIT_NS);
    checks++; if (RX_BUSY !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", RX_BUSY); end
    reset = 1'b1;
    #1;
    $display("midframe_reset: data=%h end=%b err=%b busy=%b", RX_DATA, RX_END, RX_ERR, RX_BUSY);
    checks++; if (RX_DATA !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", RX_DATA); end
    checks++; if (RX_END !== 1'b0) begin failures++; $display("FAIL midrst_end got=%b exp=0", RX_END); end
    checks++; if (RX_ERR !== 1'b0) begin failures++; $display("FAIL midrst_err got=%b exp=0", RX_ERR); end
    checks++; if (RX_BUSY !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", RX_BUSY); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #(6.0 * BIT_NS);
    e0 = end_cnt;
    send_frame(8'h12, 1'b1, BIT_NS);
    #(BIT_NS);
    $display("midframe_reset: tx=12 rx=%h ends=%0d", RX_DATA, end_cnt - e0);
    checks++; if (end_cnt - e0 !== 1) begin failures++; $display("FAIL midrst_after_end got=%0d exp=1", end_cnt - e0); end
    checks++; if (RX_DATA !== 8'h12) begin failures++; $display("FAIL midrst_after_data got=%h exp=12", RX_DATA); end
  endtask

  task automatic test_baud_tolerance();
    int e0, r0;
    e0 = end_cnt; r0 = err_cnt;
    send_frame(8'hA5, 1'b1, BIT_NS / 1.03);
    #(BIT_NS);
    $display("baud_fast: tx=A5 rx=%h", RX_DATA);
    checks++; if (RX_DATA !== 8'hA5) begin failures++; $display("FAIL baud_fast_data got=%h exp=A5", RX_DATA); end
    send_frame(8'h5A, 1'b1, BIT_NS / 0.97);
    #(BIT_NS);
    $display("baud_slow: tx=5A rx=%h", RX_DATA);
    checks++; if (RX_DATA !== 8'h5A) begin failures++; $display("FAIL baud_slow_data got=%h exp=5A", RX_DATA); end
    checks++; if (end_cnt - e0 !== 2) begin failures++; $display("FAIL baud_end_count got=%0d exp=2", end_cnt - e0); end
    checks++; if (err_cnt - r0 !== 0) begin failures++; $display("FAIL baud_err_count got=%0d exp=0", err_cnt - r0); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_break();
    test_reset_midframe();
    test_baud_tolerance();
    checks++; if (width_bad !== 0) begin failures++; $display("FAIL strobe_width_total got=%0d exp=0", width_bad); end
    checks++; if (overlap_bad !== 0) begin failures++; $display("FAIL strobe_overlap_total got=%0d exp=0", overlap_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
